// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the reset release sequencer.
package reset_seq_pkg;

  // Sequencer states: hold everything, stagger releases, steady state.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  localparam int DEF_RELEASE_GAP = 16;
  localparam int DEF_HOLD_CYC    = 8;

endpackage

// File: rtl/reset_sync_chain.sv
// Multi-flop synchroniser bringing the parent-domain reset into this clock
// domain. The chain is cleared asynchronously by the local reset.
module reset_sync_chain
  import reset_seq_pkg::*;
#(
  parameter int NUM_FLOPS = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic [NUM_FLOPS-1:0] sync_q;

  // Shift the asynchronous level through the chain; oldest bit is the output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NUM_FLOPS-2:0], async_i};
    end
  end

  assign sync_o = sync_q[NUM_FLOPS-1];

endmodule

// File: rtl/reset_seq_synth.sv
// Multi-channel reset synchroniser and staggered release sequencer.
// Optional software holds per channel are built when RESET_SEQ_SW_REQ_EN
// is defined; otherwise sw_reset_req is ignored and sw_busy is 0.
module reset_seq_synth
  import reset_seq_pkg::*;
#(
  parameter int NUM_FLOPS   = 2,
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int RELEASE_GAP = DEF_RELEASE_GAP,
  parameter int HOLD_CYC    = DEF_HOLD_CYC
) (
  input  logic              sync_clock_in,
  input  logic              reset_in_n,
  input  logic              upstream_reset_in_n,
  input  logic [NUM_CH-1:0] sw_reset_req,
  output logic [NUM_CH-1:0] reset_n_synced,
  output logic              seq_done,
  output logic              sw_busy
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RELEASE_GAP - 1);
  localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(NUM_CH - 1);

  // Elaboration-time parameter legality checks.
  if (NUM_FLOPS < 2) begin : g_chk_flops
    $error("reset_seq_synth: NUM_FLOPS must be at least 2");
  end
  if (NUM_CH < 1) begin : g_chk_ch
    $error("reset_seq_synth: NUM_CH must be at least 1");
  end
  if (RELEASE_GAP < 1 || RELEASE_GAP > (1 << CNT_W) - 1) begin : g_chk_gap
    $error("reset_seq_synth: RELEASE_GAP out of range for CNT_W");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > (1 << CNT_W) - 1) begin : g_chk_hold
    $error("reset_seq_synth: HOLD_CYC out of range for CNT_W");
  end

  logic              up_sync;
  state_e            state_q;
  logic [CNT_W-1:0]  gap_q;
  logic [IDX_W-1:0]  ch_q;        // next channel to release
  logic [NUM_CH-1:0] rst_n_q;
  logic              done_q;
  logic [NUM_CH-1:0] hold_mask;   // channels held low in RUN on this edge

  reset_sync_chain #(
    .NUM_FLOPS(NUM_FLOPS)
  ) u_sync (
    .clk_i  (sync_clock_in),
    .rst_ni (reset_in_n),
    .async_i(upstream_reset_in_n),
    .sync_o (up_sync)
  );

`ifdef RESET_SEQ_SW_REQ_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  logic [NUM_CH-1:0] hold_act_q, hold_act_d;
  logic [CNT_W-1:0]  hold_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  hold_cnt_d [NUM_CH];
  logic              busy_q;
  logic              hold_live;

  // Holds only progress in RUN with the upstream reset still released.
  assign hold_live = (state_q == ST_RUN) && up_sync;

  // Per-channel hold update: a request (re)loads, otherwise count down.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      hold_act_d[k] = hold_act_q[k];
      hold_cnt_d[k] = hold_cnt_q[k];
      if (sw_reset_req[k]) begin
        hold_act_d[k] = 1'b1;
        hold_cnt_d[k] = HOLD_LAST;
      end else if (hold_act_q[k]) begin
        if (hold_cnt_q[k] == '0) begin
          hold_act_d[k] = 1'b0;
        end else begin
          hold_cnt_d[k] = hold_cnt_q[k] - 1'b1;
        end
      end
    end
  end

  // Hold registers; cleared whenever the block is not in a live RUN state.
  always_ff @(posedge sync_clock_in or negedge reset_in_n) begin
    if (!reset_in_n) begin
      hold_act_q <= '0;
      busy_q     <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) hold_cnt_q[k] <= '0;
    end else if (hold_live) begin
      hold_act_q <= hold_act_d;
      busy_q     <= |hold_act_d;
      for (int k = 0; k < NUM_CH; k++) hold_cnt_q[k] <= hold_cnt_d[k];
    end else begin
      hold_act_q <= '0;
      busy_q     <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) hold_cnt_q[k] <= '0;
    end
  end

  assign hold_mask = hold_act_d;
  assign sw_busy   = busy_q;
`else
  logic sw_req_unused;
  assign sw_req_unused = ^sw_reset_req;
  assign hold_mask     = '0;
  assign sw_busy       = 1'b0;
`endif

  // Release sequencer with registered channel resets and done flag.
  always_ff @(posedge sync_clock_in or negedge reset_in_n) begin
    if (!reset_in_n) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      ch_q    <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (up_sync) begin
            rst_n_q <= NUM_CH'(1);
            gap_q   <= '0;
            if (NUM_CH == 1) begin
              state_q <= ST_RUN;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RELEASE;
              ch_q    <= IDX_W'(1);
            end
          end
        end
        ST_RELEASE: begin
          if (!up_sync) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            ch_q    <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
          end else if (gap_q == GAP_LAST) begin
            rst_n_q[ch_q] <= 1'b1;
            gap_q         <= '0;
            if (ch_q == LAST_CH) begin
              state_q <= ST_RUN;
              done_q  <= 1'b1;
            end else begin
              ch_q <= ch_q + 1'b1;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!up_sync) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            ch_q    <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
          end else begin
            rst_n_q <= ~hold_mask;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rst_n_q <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign reset_n_synced = rst_n_q;
  assign seq_done       = done_q;

endmodule

// File: tb/tb_reset_seq_synth.sv
// Scoreboard bench for reset_seq_synth (NUM_FLOPS=2, NUM_CH=4, gap 16, hold 8).
module tb_reset_seq_synth;

  logic       clk = 1'b0;
  logic       reset_in_n;
  logic       upstream_reset_in_n;
  logic [3:0] sw_reset_req;
  logic [3:0] reset_n_synced;
  logic       seq_done;
  logic       sw_busy;

  always #5 clk = ~clk;

  reset_seq_synth #(
    .NUM_FLOPS  (2),
    .NUM_CH     (4),
    .CNT_W      (8),
    .RELEASE_GAP(16),
    .HOLD_CYC   (8)
  ) dut (
    .sync_clock_in      (clk),
    .reset_in_n         (reset_in_n),
    .upstream_reset_in_n(upstream_reset_in_n),
    .sw_reset_req       (sw_reset_req),
    .reset_n_synced     (reset_n_synced),
    .seq_done           (seq_done),
    .sw_busy            (sw_busy)
  );

  typedef struct {
    string      name;
    int         cyc;   // -1: edge number not checked
    logic [3:0] rst;
    logic       done;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input string name, input int c, input logic [3:0] r,
                      input logic d, input logic b);
    exp_t e;
    e.name = name; e.cyc = c; e.rst = r; e.done = d; e.busy = b;
    exp_q.push_back(e);
  endtask

  // Return 1 time unit after posedge number c.
  task automatic at_edge(input int c);
    int guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (cyc < c && guard < 1000);
  endtask

  // Monitor: every change of the output tuple is one transaction.
  logic [5:0] prev_s;
  bit         first = 1'b1;
  always @(negedge clk) begin
    logic [5:0] s;
    exp_t e;
    s = {reset_n_synced, seq_done, sw_busy};
    if (first || s != prev_s) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected: cyc=%0d rst=%b done=%b busy=%b, required no change",
                 cyc, reset_n_synced, seq_done, sw_busy);
      end else begin
        e = exp_q.pop_front();
        if ((e.cyc >= 0 && e.cyc != cyc) || e.rst !== reset_n_synced ||
            e.done !== seq_done || e.busy !== sw_busy) begin
          bad++;
          $display("FAIL %s: cyc=%0d rst=%b done=%b busy=%b, required cyc=%0d rst=%b done=%b busy=%b",
                   e.name, cyc, reset_n_synced, seq_done, sw_busy,
                   e.cyc, e.rst, e.done, e.busy);
        end else begin
          $display("ok %s: cyc=%0d rst=%b done=%b busy=%b",
                   e.name, cyc, reset_n_synced, seq_done, sw_busy);
        end
      end
    end
    prev_s = s;
    first  = 1'b0;
  end

  initial begin
    int p, q, r, s, t, v;
    reset_in_n          = 1'b1;
    upstream_reset_in_n = 1'b0;
    sw_reset_req        = 4'b0000;
    #1 reset_in_n       = 1'b0;
    push("reset", -1, 4'b0000, 1'b0, 1'b0);

    // Power-up: edge 1 is p+1, channel k releases at p+3+16k.
    p = 3;
    at_edge(p);
    reset_in_n          = 1'b1;
    upstream_reset_in_n = 1'b1;
    push("pwr ch0", p + 3,  4'b0001, 1'b0, 1'b0);
    push("pwr ch1", p + 19, 4'b0011, 1'b0, 1'b0);
    push("pwr ch2", p + 35, 4'b0111, 1'b0, 1'b0);
    push("pwr ch3", p + 51, 4'b1111, 1'b1, 1'b0);

    // Upstream loss in RUN: outputs fall 3 edges later.
    q = p + 60;
    at_edge(q);
    upstream_reset_in_n = 1'b0;
    push("up loss", q + 3, 4'b0000, 1'b0, 1'b0);

    // Re-raise upstream, then pulse the async reset after channel 1.
    r = q + 10;
    at_edge(r);
    upstream_reset_in_n = 1'b1;
    push("re ch0", r + 3,  4'b0001, 1'b0, 1'b0);
    push("re ch1", r + 19, 4'b0011, 1'b0, 1'b0);
    s = r + 22;
    at_edge(s);
    reset_in_n = 1'b0;
    push("async rst", s, 4'b0000, 1'b0, 1'b0);
    t = s + 2;
    at_edge(t);
    reset_in_n = 1'b1;
    push("rst ch0", t + 3,  4'b0001, 1'b0, 1'b0);
    push("rst ch1", t + 19, 4'b0011, 1'b0, 1'b0);
    push("rst ch2", t + 35, 4'b0111, 1'b0, 1'b0);
    push("rst ch3", t + 51, 4'b1111, 1'b1, 1'b0);

    // Software request on channel 2, sampled at edge v+1.
    v = t + 60;
    at_edge(v);
    sw_reset_req = 4'b0100;
`ifdef RESET_SEQ_SW_REQ_EN
    push("sw hold", v + 1, 4'b1011, 1'b1, 1'b1);
    push("sw rel",  v + 9, 4'b1111, 1'b1, 1'b0);
`endif
    at_edge(v + 1);
    sw_reset_req = 4'b0000;

`ifdef RESET_SEQ_SW_REQ_EN
    begin
      int w, x;
      // Reload: requests sampled at w+1 and w+6, release at w+14.
      w = v + 20;
      at_edge(w);
      sw_reset_req = 4'b0100;
      push("reload hold", w + 1,  4'b1011, 1'b1, 1'b1);
      push("reload rel",  w + 14, 4'b1111, 1'b1, 1'b0);
      at_edge(w + 1);
      sw_reset_req = 4'b0000;
      at_edge(w + 5);
      sw_reset_req = 4'b0100;
      at_edge(w + 6);
      sw_reset_req = 4'b0000;

      // Collision: request sampled at x+1, upstream loss seen at x+4.
      x = w + 30;
      at_edge(x);
      sw_reset_req = 4'b0100;
      push("coll hold", x + 1, 4'b1011, 1'b1, 1'b1);
      push("coll loss", x + 4, 4'b0000, 1'b0, 1'b0);
      at_edge(x + 1);
      sw_reset_req        = 4'b0000;
      upstream_reset_in_n = 1'b0;
    end
`else
    at_edge(v + 16);
    total++;
    if (reset_n_synced !== 4'b1111 || seq_done !== 1'b1 || sw_busy !== 1'b0) begin
      bad++;
      $display("FAIL no sw hold: rst=%b done=%b busy=%b, required rst=1111 done=1 busy=0",
               reset_n_synced, seq_done, sw_busy);
    end else begin
      $display("ok no sw hold: rst=%b done=%b busy=%b", reset_n_synced, seq_done, sw_busy);
    end
`endif

    repeat (20) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending: %0d expected events not seen, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
